pipe_stage6_state_update: RTL and testbench

- Stage directly downstream of pipe_stage5 in the DAL datapath.
- Per lane, it registers the stage-5 results (alpha, alpha-scaled, beta) through a 2-entry output buffer with valid/ready handshakes on both sides.
- It owns the per-lane interval histogram, max-count and mode registers that feed back into stage 5.
- It counts processed elements against J_size and sequences run/drain/done.

---
 rtl/pipe_stage6_state_update.sv | 225 ++++++++++++++++++++++
 tb/tb_pipe_stage6_state_update.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage6_state_update.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage6_state_update
// Purpose  : DAL datapath stage 6. Buffers stage-5 results (alpha,
//            alpha-scaled, beta) for every lane in a 2-entry output FIFO with
//            valid/ready on both sides. Owns the per-lane interval histogram,
//            max bin count and mode (argmax interval) that feed back into
//            stage 5. Counts accepted elements against J_size and sequences
//            IDLE -> RUN -> DRAIN -> DONE.
// Ports    : CLK_i, RST_ni (async, active-low)
//            start_i / clr_i / J_size_i      row control
//            in_valid_i / in_ready_o         stage-5 handshake
//            acc_interval_i, alpha_i, alpha_n_i, beta_i   per-lane inputs
//            out_valid_o / out_ready_i       consumer handshake
//            alpha_o, alpha_n_o, beta_o      FIFO head
//            interval_cnt_o, max_cnt_o, mode_o   feedback to stage 5
//            elem_cnt_o, done_o, err_o       status
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage6_state_update #(
    parameter int WIDTH         = 16,
    parameter int INTERVAL_SIZE = 8,
    parameter int PARA          = 16,
    parameter int PARALLEL_SIZE = 2
) (
    input  logic                                                CLK_i,
    input  logic                                                RST_ni,
    input  logic                                                start_i,
    input  logic                                                clr_i,
    input  logic [PARA-1:0]                                     J_size_i,
    input  logic                                                in_valid_i,
    output logic                                                in_ready_o,
    input  logic [PARALLEL_SIZE-1:0][INTERVAL_SIZE-1:0]         acc_interval_i,
    input  logic [PARALLEL_SIZE-1:0][WIDTH-1:0]                 alpha_i,
    input  logic [PARALLEL_SIZE-1:0][WIDTH-1:0]                 alpha_n_i,
    input  logic [PARALLEL_SIZE-1:0][WIDTH-1:0]                 beta_i,
    output logic                                                out_valid_o,
    input  logic                                                out_ready_i,
    output logic [PARALLEL_SIZE-1:0][WIDTH-1:0]                 alpha_o,
    output logic [PARALLEL_SIZE-1:0][WIDTH-1:0]                 alpha_n_o,
    output logic [PARALLEL_SIZE-1:0][WIDTH-1:0]                 beta_o,
    output logic [PARALLEL_SIZE-1:0][INTERVAL_SIZE-1:0][PARA-1:0] interval_cnt_o,
    output logic [PARALLEL_SIZE-1:0][PARA-1:0]                  max_cnt_o,
    output logic [PARALLEL_SIZE-1:0][INTERVAL_SIZE-1:0]         mode_o,
    output logic [PARA-1:0]                                     elem_cnt_o,
    output logic                                                done_o,
    output logic                                                err_o
);

    // One beat carries all three data vectors of all lanes.
    localparam int BEAT_W = 3 * PARALLEL_SIZE * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                                              state_q, state_d;
    logic [PARA-1:0]                                     jsize_q, jsize_d;
    logic [1:0][BEAT_W-1:0]                              mem_q, mem_d;
    logic                                                wr_ptr_q, wr_ptr_d;
    logic                                                rd_ptr_q, rd_ptr_d;
    logic [1:0]                                          count_q, count_d;
    logic [PARALLEL_SIZE-1:0][INTERVAL_SIZE-1:0][PARA-1:0] bin_q, bin_d;
    logic [PARALLEL_SIZE-1:0][PARA-1:0]                  max_q, max_d;
    logic [PARALLEL_SIZE-1:0][INTERVAL_SIZE-1:0]         mode_q, mode_d;
    logic [PARA-1:0]                                     elem_q, elem_d;
    logic                                                err_q, err_d;

    logic              accept;
    logic              pop;
    logic [BEAT_W-1:0] beat_in;
    logic [BEAT_W-1:0] head_beat;
    logic [PARA-1:0]   inc_cnt;

    function automatic logic is_onehot(input logic [INTERVAL_SIZE-1:0] v);
        return (v != '0) && ((v & (v - INTERVAL_SIZE'(1))) == '0);
    endfunction

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [PARA-1:0] sat_inc(input logic [PARA-1:0] v);
        return (v == '1) ? v : (v + PARA'(1));
    endfunction

    // Ready is a function of local state only, so stage 5 never sees a
    // combinational path from the downstream consumer.
    assign in_ready_o  = (state_q == S_RUN) && (count_q < 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign accept      = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    assign beat_in   = {alpha_i, alpha_n_i, beta_i};
    // Gate the head with valid so an empty buffer always presents zeros.
    assign head_beat = out_valid_o ? mem_q[rd_ptr_q] : '0;
    assign {alpha_o, alpha_n_o, beta_o} = head_beat;

    assign interval_cnt_o = bin_q;
    assign max_cnt_o      = max_q;
    assign mode_o         = mode_q;
    assign elem_cnt_o     = elem_q;
    assign err_o          = err_q;
    assign done_o         = (state_q == S_DONE);

    always_comb begin
        state_d  = state_q;
        jsize_d  = jsize_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        bin_d    = bin_q;
        max_d    = max_q;
        mode_d   = mode_q;
        elem_d   = elem_q;
        err_d    = err_q;
        inc_cnt  = '0;

        // Output buffer; push and pop may coincide at any occupancy.
        if (accept) begin
            mem_d[wr_ptr_q] = beat_in;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // Histogram / max / mode, each lane independent. Strict compare so a
        // tie leaves the earlier mode in place.
        if (accept) begin
            for (int i = 0; i < PARALLEL_SIZE; i++) begin
                if (is_onehot(acc_interval_i[i])) begin
                    for (int j = 0; j < INTERVAL_SIZE; j++) begin
                        if (acc_interval_i[i][j]) begin
                            inc_cnt     = sat_inc(bin_q[i][j]);
                            bin_d[i][j] = inc_cnt;
                            if (inc_cnt > max_q[i]) begin
                                max_d[i]  = inc_cnt;
                                mode_d[i] = acc_interval_i[i];
                            end
                        end
                    end
                end else begin
                    err_d = 1'b1;
                end
            end
            elem_d = sat_inc(elem_q);
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                // A start from DONE implicitly clears the previous row.
                if (start_i) begin
                    jsize_d = J_size_i;
                    bin_d   = '0;
                    max_d   = '0;
                    mode_d  = '0;
                    elem_d  = '0;
                    err_d   = 1'b0;
                    state_d = (J_size_i != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (accept && ((elem_q + PARA'(1)) == jsize_q)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (count_q == 2'd0) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Clear wins over start and over a same-cycle accept.
        if (clr_i) begin
            state_d  = S_IDLE;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
            bin_d    = '0;
            max_d    = '0;
            mode_d   = '0;
            elem_d   = '0;
            err_d    = 1'b0;
        end
    end

    always_ff @(posedge CLK_i or negedge RST_ni) begin
        if (!RST_ni) begin
            state_q  <= S_IDLE;
            jsize_q  <= '0;
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            bin_q    <= '0;
            max_q    <= '0;
            mode_q   <= '0;
            elem_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            jsize_q  <= jsize_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            bin_q    <= bin_d;
            max_q    <= max_d;
            mode_q   <= mode_d;
            elem_q   <= elem_d;
            err_q    <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage6_state_update.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage6_state_update
// Purpose  : Self-checking bench for pipe_stage6_state_update. Accepted beats
//            are queued as expected output; a monitor pops and compares on
//            every output handshake. Scenario tasks check counters/state.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage6_state_update;

    logic                    clk_i = 1'b0;
    logic                    rst_ni;
    logic                    start_i, clr_i, in_valid_i, out_ready_i;
    logic [15:0]             j_size_i;
    logic                    in_ready_o, out_valid_o, done_o, err_o;
    logic [1:0][7:0]         acc_interval_i;
    logic [1:0][15:0]        alpha_i, alpha_n_i, beta_i;
    logic [1:0][15:0]        alpha_o, alpha_n_o, beta_o;
    logic [1:0][7:0][15:0]   interval_cnt_o;
    logic [1:0][15:0]        max_cnt_o;
    logic [1:0][7:0]         mode_o;
    logic [15:0]             elem_cnt_o;

    typedef struct packed {
        logic [1:0][15:0] a;
        logic [1:0][15:0] an;
        logic [1:0][15:0] b;
    } beat_t;

    beat_t sb_q[$];
    beat_t exp_beat;
    int    checks = 0;
    int    errors = 0;

    pipe_stage6_state_update #(
        .WIDTH(16), .INTERVAL_SIZE(8), .PARA(16), .PARALLEL_SIZE(2)
    ) dut (
        .CLK_i(clk_i), .RST_ni(rst_ni), .start_i(start_i), .clr_i(clr_i),
        .J_size_i(j_size_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .acc_interval_i(acc_interval_i), .alpha_i(alpha_i),
        .alpha_n_i(alpha_n_i), .beta_i(beta_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .alpha_o(alpha_o), .alpha_n_o(alpha_n_o),
        .beta_o(beta_o), .interval_cnt_o(interval_cnt_o),
        .max_cnt_o(max_cnt_o), .mode_o(mode_o), .elem_cnt_o(elem_cnt_o),
        .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Output monitor: a handshake seen at the falling edge completes at the
    // next rising edge; the head must equal the oldest accepted beat.
    always @(negedge clk_i) begin
        if (rst_ni && out_valid_o && out_ready_i) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: got %h, expected no beat",
                         {alpha_o, alpha_n_o, beta_o});
            end else begin
                exp_beat = sb_q.pop_front();
                if ({alpha_o, alpha_n_o, beta_o} !== exp_beat) begin
                    errors++;
                    $display("FAIL sb_data: got %h expected %h",
                             {alpha_o, alpha_n_o, beta_o}, exp_beat);
                end
            end
        end
    end

    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_start(input logic [15:0] j);
        start_i  = 1'b1;
        j_size_i = j;
        tick();
        start_i  = 1'b0;
    endtask

    task automatic do_clr();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
    endtask

    task automatic send(input logic [7:0] iv0, input logic [7:0] iv1);
        bit ok;
        ok = 1'b0;
        in_valid_i        = 1'b1;
        acc_interval_i[0] = iv0;
        acc_interval_i[1] = iv1;
        alpha_i   = 32'($urandom);
        alpha_n_i = 32'($urandom);
        beta_i    = 32'($urandom);
        for (int t = 0; t < 50; t++) begin
            @(negedge clk_i);
            if (in_ready_o === 1'b1) begin
                sb_q.push_back({alpha_i, alpha_n_i, beta_i});
                ok = 1'b1;
            end
            tick();
            if (ok) break;
        end
        in_valid_i = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: in_ready_o=%b expected 1", in_ready_o);
        end
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 30; t++) begin
            if (done_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL done_timeout: done_o=%b expected 1", done_o);
        end
    endtask

    task automatic check_cleared(input string tag);
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b0 || done_o !== 1'b0 ||
            err_o !== 1'b0 || elem_cnt_o !== 16'd0 || max_cnt_o !== '0 ||
            mode_o !== '0 || interval_cnt_o !== '0) begin
            errors++;
            $display("FAIL %s: ov=%b ir=%b done=%b err=%b elem=%0d max=%h mode=%h bins=%h, expected all zero",
                     tag, out_valid_o, in_ready_o, done_o, err_o, elem_cnt_o,
                     max_cnt_o, mode_o, interval_cnt_o);
        end
        checks++;
        if ({alpha_o, alpha_n_o, beta_o} !== '0) begin
            errors++;
            $display("FAIL %s_data: got %h expected 0", tag,
                     {alpha_o, alpha_n_o, beta_o});
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #2;
        check_cleared("reset_asserted");
        #20;
        rst_ni = 1'b1;
        tick();
        check_cleared("reset_released");
    endtask

    task automatic test_basic();
        out_ready_i = 1'b1;
        do_start(16'd4);
        checks++;
        if (in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_ready: in_ready_o=%b expected 1", in_ready_o);
        end
        send(8'h04, 8'h01);
        checks++;
        if (interval_cnt_o[0][2] !== 16'd1 || max_cnt_o[0] !== 16'd1 ||
            mode_o[0] !== 8'h04 || elem_cnt_o !== 16'd1) begin
            errors++;
            $display("FAIL basic_first: bin=%0d max=%0d mode=%h elem=%0d expected 1 1 04 1",
                     interval_cnt_o[0][2], max_cnt_o[0], mode_o[0], elem_cnt_o);
        end
        for (int k = 0; k < 3; k++) send(8'h04, 8'h01);
        checks++;
        if (interval_cnt_o[0][2] !== 16'd4 || max_cnt_o[0] !== 16'd4 ||
            mode_o[0] !== 8'h04 || elem_cnt_o !== 16'd4 ||
            interval_cnt_o[1][0] !== 16'd4 || mode_o[1] !== 8'h01) begin
            errors++;
            $display("FAIL basic_final: bin0=%0d max0=%0d mode0=%h elem=%0d bin1=%0d mode1=%h expected 4 4 04 4 4 01",
                     interval_cnt_o[0][2], max_cnt_o[0], mode_o[0], elem_cnt_o,
                     interval_cnt_o[1][0], mode_o[1]);
        end
        checks++;
        if (done_o !== 1'b0 || in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain0: done=%b ir=%b expected 0 0", done_o, in_ready_o);
        end
        tick();
        checks++;
        if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain1: done=%b expected 0", done_o);
        end
        tick();
        checks++;
        if (done_o !== 1'b1 || out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: done=%b ov=%b expected 1 0", done_o, out_valid_o);
        end
        do_clr();
        check_cleared("basic_clr");
    endtask

    task automatic test_backpressure();
        out_ready_i = 1'b0;
        do_start(16'd3);
        send(8'h01, 8'h01);
        send(8'h01, 8'h01);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            checks++;
            if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1 ||
                {alpha_o, alpha_n_o, beta_o} !== sb_q[0]) begin
                errors++;
                $display("FAIL bp_stall: ir=%b ov=%b data=%h expected 0 1 %h",
                         in_ready_o, out_valid_o, {alpha_o, alpha_n_o, beta_o}, sb_q[0]);
            end
            tick();
        end
        out_ready_i = 1'b1;
        send(8'h01, 8'h01);
        wait_done();
        checks++;
        if (sb_q.size() != 0 || elem_cnt_o !== 16'd3) begin
            errors++;
            $display("FAIL bp_drained: left=%0d elem=%0d expected 0 3", sb_q.size(), elem_cnt_o);
        end
        do_clr();
    endtask

    task automatic test_tie_mode();
        logic [7:0] seq [4];
        seq[0] = 8'h01; seq[1] = 8'h02; seq[2] = 8'h02; seq[3] = 8'h01;
        out_ready_i = 1'b1;
        do_start(16'd4);
        for (int k = 0; k < 4; k++) begin
            send(8'h80, seq[k]);
            if (k == 2) begin
                checks++;
                if (max_cnt_o[1] !== 16'd2 || mode_o[1] !== 8'h02) begin
                    errors++;
                    $display("FAIL tie_mid: max1=%0d mode1=%h expected 2 02", max_cnt_o[1], mode_o[1]);
                end
            end
        end
        checks++;
        if (max_cnt_o[1] !== 16'd2 || mode_o[1] !== 8'h02 ||
            interval_cnt_o[1][0] !== 16'd2 || interval_cnt_o[1][1] !== 16'd2 ||
            interval_cnt_o[0][7] !== 16'd4 || mode_o[0] !== 8'h80) begin
            errors++;
            $display("FAIL tie_final: max1=%0d mode1=%h b10=%0d b11=%0d b07=%0d mode0=%h expected 2 02 2 2 4 80",
                     max_cnt_o[1], mode_o[1], interval_cnt_o[1][0],
                     interval_cnt_o[1][1], interval_cnt_o[0][7], mode_o[0]);
        end
        wait_done();
        do_clr();
    endtask

    task automatic test_invalid();
        out_ready_i = 1'b1;
        do_start(16'd3);
        send(8'h00, 8'h01);
        checks++;
        if (err_o !== 1'b1 || interval_cnt_o[0] !== '0 || max_cnt_o[0] !== 16'd0 ||
            elem_cnt_o !== 16'd1) begin
            errors++;
            $display("FAIL inv_zero: err=%b bins0=%h max0=%0d elem=%0d expected 1 0 0 1",
                     err_o, interval_cnt_o[0], max_cnt_o[0], elem_cnt_o);
        end
        send(8'h03, 8'h01);
        checks++;
        if (err_o !== 1'b1 || interval_cnt_o[0] !== '0 || mode_o[0] !== 8'h00 ||
            elem_cnt_o !== 16'd2) begin
            errors++;
            $display("FAIL inv_multi: err=%b bins0=%h mode0=%h elem=%0d expected 1 0 00 2",
                     err_o, interval_cnt_o[0], mode_o[0], elem_cnt_o);
        end
        send(8'h10, 8'h01);
        checks++;
        if (err_o !== 1'b1 || interval_cnt_o[0][4] !== 16'd1 || mode_o[0] !== 8'h10 ||
            interval_cnt_o[1][0] !== 16'd3) begin
            errors++;
            $display("FAIL inv_sticky: err=%b b04=%0d mode0=%h b10=%0d expected 1 1 10 3",
                     err_o, interval_cnt_o[0][4], mode_o[0], interval_cnt_o[1][0]);
        end
        wait_done();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL inv_out: %0d beats not output, expected 0", sb_q.size());
        end
    endtask

    task automatic test_jzero();
        // Start from DONE (left by the previous row) clears everything first.
        do_start(16'd0);
        checks++;
        if (done_o !== 1'b1 || err_o !== 1'b0 || elem_cnt_o !== 16'd0 ||
            interval_cnt_o !== '0) begin
            errors++;
            $display("FAIL jz_from_done: done=%b err=%b elem=%0d bins=%h expected 1 0 0 0",
                     done_o, err_o, elem_cnt_o, interval_cnt_o);
        end
        do_clr();
        checks++;
        if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL jz_clr: done=%b expected 0", done_o);
        end
        do_start(16'd0);
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL jz_idle: done=%b expected 1", done_o);
        end
        in_valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            checks++;
            if (in_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL jz_ready: in_ready_o=%b expected 0", in_ready_o);
            end
            tick();
        end
        in_valid_i = 1'b0;
        do_clr();
    endtask

    task automatic test_clr();
        out_ready_i = 1'b0;
        do_start(16'd5);
        send(8'h02, 8'h02);
        // Offer a beat in the same cycle as clr; clr must win.
        in_valid_i = 1'b1;
        clr_i      = 1'b1;
        @(negedge clk_i);
        checks++;
        if (in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL clr_pre: in_ready_o=%b expected 1", in_ready_o);
        end
        tick();
        in_valid_i = 1'b0;
        clr_i      = 1'b0;
        sb_q.delete();
        check_cleared("clr_accept");
        out_ready_i = 1'b1;
        do_start(16'd1);
        send(8'h40, 8'h20);
        wait_done();
        checks++;
        if (sb_q.size() != 0 || elem_cnt_o !== 16'd1 || interval_cnt_o[0][6] !== 16'd1 ||
            interval_cnt_o[0][1] !== 16'd0) begin
            errors++;
            $display("FAIL clr_after: left=%0d elem=%0d b06=%0d b01=%0d expected 0 1 1 0",
                     sb_q.size(), elem_cnt_o, interval_cnt_o[0][6], interval_cnt_o[0][1]);
        end
        do_clr();
    endtask

    task automatic test_async_reset();
        out_ready_i = 1'b0;
        do_start(16'd4);
        send(8'h08, 8'h08);
        send(8'h08, 8'h08);
        checks++;
        if (out_valid_o !== 1'b1 || elem_cnt_o !== 16'd2) begin
            errors++;
            $display("FAIL ar_pre: ov=%b elem=%0d expected 1 2", out_valid_o, elem_cnt_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        check_cleared("ar_mid");
        sb_q.delete();
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        check_cleared("ar_release");
        out_ready_i = 1'b1;
        do_start(16'd2);
        send(8'h01, 8'h80);
        send(8'h01, 8'h80);
        wait_done();
        checks++;
        if (elem_cnt_o !== 16'd2 || interval_cnt_o[0][0] !== 16'd2 ||
            interval_cnt_o[0][3] !== 16'd0 || err_o !== 1'b0 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL ar_fresh: elem=%0d b00=%0d b03=%0d err=%b left=%0d expected 2 2 0 0 0",
                     elem_cnt_o, interval_cnt_o[0][0], interval_cnt_o[0][3], err_o, sb_q.size());
        end
    endtask

    initial begin
        start_i = 1'b0; clr_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        j_size_i = '0; acc_interval_i = '0;
        alpha_i = '0; alpha_n_i = '0; beta_i = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_tie_mode();
        test_invalid();
        test_jzero();
        test_clr();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
